sobel_edge_proc: RTL

- Streaming 3x3 Sobel edge detector placed directly downstream of the median-filter stage in the video image processor.
- Consumes the filtered grey stream (vsync/href/gray) and emits a binary edge map: 8'hFF for an edge, 8'h00 otherwise.
- Output timing is the same as the input frame timing, delayed by a fixed number of clocks.
- Output feeds the surveillance/motion logic.

---
 rtl/sobel_edge_proc.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sobel_edge_proc.sv
// -----------------------------------------------------------------------------
// sobel_edge_proc
//   Streaming 3x3 Sobel edge detector for the grey video stream. Produces a
//   binary edge map (8'hFF edge / 8'h00 no edge) aligned to the input frame
//   timing, delayed by exactly four clocks.
//
// Ports
//   clk             pixel clock, rising edge
//   rst             asynchronous active-high reset
//   edge_thresh     runtime threshold, captured on each vsync rising edge
//   per_img_vsync   input frame sync
//   per_img_href    input line valid, one pixel per clock while high
//   per_img_gray    input grey pixel
//   post_img_vsync  per_img_vsync delayed 4 clocks
//   post_img_href   per_img_href delayed 4 clocks
//   post_img_gray   edge result, 8'hFF or 8'h00
// -----------------------------------------------------------------------------
module sobel_edge_proc #(
   parameter logic [10:0] IMG_HDISP       = 11'd640,
   parameter logic [10:0] IMG_VDISP       = 11'd480,
   parameter logic [7:0]  EDGE_THRESH_DEF = 8'd64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] edge_thresh,
   input  logic       per_img_vsync,
   input  logic       per_img_href,
   input  logic [7:0] per_img_gray,
   output logic       post_img_vsync,
   output logic       post_img_href,
   output logic [7:0] post_img_gray
);

   localparam int          AW      = $clog2(int'(IMG_HDISP));
   localparam logic [10:0] COL_MAX = IMG_HDISP - 11'd1;
   localparam logic [10:0] ROW_MAX = IMG_VDISP - 11'd1;

   // ---------------- input edge detection, counters, frame state -------------
   logic        vs_prev_q, hr_prev_q;
   logic [10:0] col_q, col_d, row_q, row_d, row_cur;
   logic        frame_ok_q, frame_ok_d;
   logic [7:0]  thresh_q, thresh_d;
   logic        vs_rise, hr_fall;

   assign vs_rise = per_img_vsync & ~vs_prev_q;
   assign hr_fall = ~per_img_href & hr_prev_q;
   // A vsync rise coinciding with an active pixel makes that line row 0.
   assign row_cur = vs_rise ? '0 : row_q;

   always_comb begin
      col_d = col_q;
      if (per_img_href) begin
         if (col_q != COL_MAX) col_d = col_q + 11'd1;
      end else if (hr_fall) begin
         col_d = '0;
      end
      row_d = row_q;
      if (vs_rise) row_d = '0;
      else if (hr_fall && row_q != ROW_MAX) row_d = row_q + 11'd1;
      frame_ok_d = frame_ok_q | vs_rise;
      thresh_d   = vs_rise ? edge_thresh : thresh_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_prev_q  <= 1'b0;
         hr_prev_q  <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
         frame_ok_q <= 1'b0;
         thresh_q   <= EDGE_THRESH_DEF;
      end else begin
         vs_prev_q  <= per_img_vsync;
         hr_prev_q  <= per_img_href;
         col_q      <= col_d;
         row_q      <= row_d;
         frame_ok_q <= frame_ok_d;
         thresh_q   <= thresh_d;
      end
   end

   // ---------------- line buffers (rows r-1 and r-2) --------------------------
   logic [7:0]    lb1_mem [0:IMG_HDISP-1];
   logic [7:0]    lb2_mem [0:IMG_HDISP-1];
   logic [7:0]    lb1_rd_q, lb2_rd_q;
   logic [AW-1:0] addr;

   assign addr = col_q[AW-1:0];

   // Read-before-write: buffer 2 receives the row that buffer 1 is giving up.
   always_ff @(posedge clk) begin
      if (per_img_href) begin
         lb1_rd_q      <= lb1_mem[addr];
         lb2_rd_q      <= lb2_mem[addr];
         lb1_mem[addr] <= per_img_gray;
         lb2_mem[addr] <= lb1_mem[addr];
      end
   end

   // ---------------- pipeline S1..S4 ------------------------------------------
   logic       s1_href_q, s1_vs_q, s1_border_q, s1_ok_q;
   logic [7:0] s1_pix_q;
   logic       s2_href_q, s2_vs_q, s2_border_q, s2_ok_q;
   logic [7:0] p11_q, p12_q, p13_q, p21_q, p22_q, p23_q, p31_q, p32_q, p33_q;
   logic       s3_href_q, s3_vs_q, s3_valid_q;
   logic [10:0] gx_q, gy_q, gx_d, gy_d;
   logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg, abs_x, abs_y, mag;
   logic       post_vsync_q, post_href_q;
   logic [7:0] post_gray_q;

   always_comb begin
      gx_pos = {3'b000, p13_q} + {2'b00, p23_q, 1'b0} + {3'b000, p33_q};
      gx_neg = {3'b000, p11_q} + {2'b00, p21_q, 1'b0} + {3'b000, p31_q};
      gy_pos = {3'b000, p31_q} + {2'b00, p32_q, 1'b0} + {3'b000, p33_q};
      gy_neg = {3'b000, p11_q} + {2'b00, p12_q, 1'b0} + {3'b000, p13_q};
      gx_d   = gx_pos - gx_neg;
      gy_d   = gy_pos - gy_neg;
      abs_x  = gx_q[10] ? (~gx_q + 11'd1) : gx_q;
      abs_y  = gy_q[10] ? (~gy_q + 11'd1) : gy_q;
      mag    = abs_x + abs_y;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_href_q <= 1'b0; s1_vs_q <= 1'b0; s1_border_q <= 1'b0; s1_ok_q <= 1'b0;
         s1_pix_q  <= '0;
         s2_href_q <= 1'b0; s2_vs_q <= 1'b0; s2_border_q <= 1'b0; s2_ok_q <= 1'b0;
         p11_q <= '0; p12_q <= '0; p13_q <= '0;
         p21_q <= '0; p22_q <= '0; p23_q <= '0;
         p31_q <= '0; p32_q <= '0; p33_q <= '0;
         s3_href_q <= 1'b0; s3_vs_q <= 1'b0; s3_valid_q <= 1'b0;
         gx_q <= '0; gy_q <= '0;
         post_vsync_q <= 1'b0; post_href_q <= 1'b0; post_gray_q <= '0;
      end else begin
         // S1: input register alongside the RAM read; border decided from the
         // pixel's own row/column and carried with it.
         s1_href_q   <= per_img_href;
         s1_vs_q     <= per_img_vsync;
         s1_pix_q    <= per_img_gray;
         s1_border_q <= (row_cur < 11'd2) || (col_q < 11'd2);
         s1_ok_q     <= frame_ok_q | vs_rise;
         // S2: window shift (top row = r-2, bottom row = r)
         s2_href_q   <= s1_href_q;
         s2_vs_q     <= s1_vs_q;
         s2_border_q <= s1_border_q;
         s2_ok_q     <= s1_ok_q;
         if (s1_href_q) begin
            p11_q <= p12_q; p12_q <= p13_q; p13_q <= lb2_rd_q;
            p21_q <= p22_q; p22_q <= p23_q; p23_q <= lb1_rd_q;
            p31_q <= p32_q; p32_q <= p33_q; p33_q <= s1_pix_q;
         end
         // S3: gradients
         s3_href_q  <= s2_href_q;
         s3_vs_q    <= s2_vs_q;
         s3_valid_q <= s2_href_q & s2_ok_q & ~s2_border_q;
         gx_q       <= gx_d;
         gy_q       <= gy_d;
         // S4: magnitude and threshold
         post_vsync_q <= s3_vs_q;
         post_href_q  <= s3_href_q;
         post_gray_q  <= (s3_valid_q && (mag > {3'b000, thresh_q})) ? 8'hFF : 8'h00;
      end
   end

   assign post_img_vsync = post_vsync_q;
   assign post_img_href  = post_href_q;
   assign post_img_gray  = post_gray_q;

endmodule
